// File: rtl/cache_refill_pkg.sv
// rtl/cache_refill_pkg.sv - shared FSM type, requester indices and AXI encodings for the refill arbiter
package cache_refill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } refill_state_t;

  localparam int unsigned REQ_INSTR = 0;
  localparam int unsigned REQ_DATA  = 1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// rtl/cache_refill_arbiter_if.sv - request/response and AXI4 read bundle shared by arbiter and its environment
interface cache_refill_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                 req_valid;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0]                 req_ready;

  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    input  req_valid, req_addr, rsp_ready, arready, rvalid, rdata, rresp, rlast,
    output req_ready, rsp_valid, rsp_data, rsp_last,
    output arvalid, araddr, arlen, arsize, arburst, rready
  );

  modport slave (
    output req_valid, req_addr, rsp_ready, arready, rvalid, rdata, rresp, rlast,
    input  req_ready, rsp_valid, rsp_data, rsp_last,
    input  arvalid, araddr, arlen, arsize, arburst, rready
  );

endinterface

// File: rtl/cache_refill_arbiter_rr.sv
// rtl/cache_refill_arbiter_rr.sv - two-input round-robin grant; pointer moves to the other requester on advance
module rr_arbiter_2
  import cache_refill_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       last_owner,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic ptr_q;
  logic ptr_d;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt     = req;
    gnt_idx = req[REQ_DATA] & ~req[REQ_INSTR];
    if (req == 2'b11) begin
      gnt_idx = ptr_q;
      gnt     = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = ~last_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'(REQ_INSTR);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// rtl/cache_refill_arbiter.sv - shares one AXI4 read port between I- and D-cache line fills
// Define REFILL_ARB_ERR_CHECK_EN to build the sticky rresp/rlast error flag.
module cache_refill_arbiter
  import cache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_refill_arbiter_if.master bus,
  output logic                   err
);

  localparam int CNT_W    = $clog2(LINE_WORDS);
  localparam int OFF_BITS = $clog2(LINE_WORDS * 4);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_BITS) - 1);

  refill_state_t         state_q,   state_d;
  logic                  owner_q,   owner_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [7:0]            arlen_q,   arlen_d;
  logic [2:0]            arsize_q,  arsize_d;
  logic [1:0]            arburst_q, arburst_d;

  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       req_hs;
  logic       beat_hs;
  logic       last_beat;
  logic       burst_done;

  // Arbitration is only open in IDLE, and never while reset is asserted.
  assign arb_req    = (state_q == IDLE && !rst) ? bus.req_valid : 2'b00;
  assign req_hs     = |gnt;
  assign last_beat  = (cnt_q == LAST_BEAT);
  assign beat_hs    = (state_q == DATA) && bus.rvalid && bus.rready;
  assign burst_done = beat_hs && last_beat;

  rr_arbiter_2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (arb_req),
    .advance    (burst_done),
    .last_owner (owner_q),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = araddr_q;
  assign bus.arlen     = arlen_q;
  assign bus.arsize    = arsize_q;
  assign bus.arburst   = arburst_q;

  // R channel is a straight pass-through to the current owner.
  always_comb begin
    bus.rsp_valid = 2'b00;
    bus.rready    = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_last  = 1'b0;
    if (state_q == DATA) begin
      bus.rsp_valid[owner_q] = bus.rvalid;
      bus.rready             = bus.rsp_ready[owner_q];
      bus.rsp_data           = bus.rdata;
      bus.rsp_last           = last_beat;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          owner_d   = gnt_idx;
          araddr_d  = bus.req_addr[gnt_idx] & LINE_MASK;
          arvalid_d = 1'b1;
          arlen_d   = 8'(LINE_WORDS - 1);
          arsize_d  = SIZE_WORD;
          arburst_d = BURST_INCR;
          cnt_d     = '0;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (bus.arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (beat_hs) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

`ifdef REFILL_ARB_ERR_CHECK_EN
  logic err_q;
  logic err_d;

  // The burst length is governed by the counter; rlast is only cross-checked.
  always_comb begin
    err_d = err_q;
    if (beat_hs && (bus.rresp != 2'b00 || bus.rlast != last_beat)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{bus.rresp, bus.rlast};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb/tb_cache_refill_arbiter.sv - directed self-checking bench with a transaction-level model of the arbiter
`timescale 1ns/1ps
module tb_cache_refill_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam logic [AW-1:0] LMASK = ~AW'(LW * 4 - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  always #5 clk = ~clk;

  cache_refill_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cache_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs
  int pend [2];
  int done_cnt [2];
  logic [AW-1:0] base [2];
  bit waiting [2];
  bit stall_en, gap_en;
  int ar_delay, err_beat, cyc;

  // Memory-side slave state
  bit sl_busy, gap_ph;
  logic [AW-1:0] sl_addr;
  int sl_beat, sl_wait;

  // Values observed at the falling edge, consumed after the next rising edge
  bit nm_rst, nm_arv, nm_ar_hs, nm_r_hs;
  logic [1:0] nm_req_hs, nm_last_hs;
  logic [AW-1:0] nm_araddr;

  // Transaction-level model
  int m_owner, m_beat, m_prio, mg;
  bit m_ar, m_err;
  logic [AW-1:0] m_addr;
  logic [1:0] exp_rr, exp_rspv;
  bit exp_arv, exp_rready, exp_last;

  // Event logs for the literal checks
  int hs_order[$];
  int hs_cyc[$];
  logic [31:0] log0[$];
  logic [31:0] log1[$];
  bit err_log[$];
  int first_beat_cyc, last_beat_cyc, n_lastflag, lastflag_pos, ar_stall;
  logic [AW-1:0] ar_cap_addr;
  logic [7:0] ar_cap_len;

  initial begin
    bus.req_valid = 2'b00;
    bus.req_addr  = '0;
    bus.rsp_ready = 2'b11;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = 2'b00;
    bus.rlast     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (nm_rst) begin
          waiting[i] = 1'b0;
        end else begin
          if (nm_req_hs[i]) begin
            waiting[i] = 1'b1;
            pend[i]--;
            done_cnt[i]++;
          end
          if (nm_last_hs[i]) waiting[i] = 1'b0;
        end
        bus.req_valid[i] = (pend[i] > 0) && !waiting[i];
        bus.req_addr[i]  = base[i] + AW'(done_cnt[i] * 16);
      end
      bus.rsp_ready = (stall_en && (cyc % 3 == 1)) ? 2'b00 : 2'b11;
      if (nm_rst) begin
        sl_busy = 1'b0; sl_beat = 0; sl_wait = 0;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
      end else begin
        if (nm_ar_hs) begin
          sl_busy = 1'b1; sl_addr = nm_araddr; sl_beat = 0; sl_wait = 0;
        end else if (nm_arv) begin
          sl_wait++;
        end
        if (nm_r_hs) sl_beat++;
        if (sl_busy && sl_beat == LW) sl_busy = 1'b0;
        bus.arready = !sl_busy && (sl_wait >= ar_delay);
        if (!(bus.rvalid && !nm_r_hs)) begin
          gap_ph = !gap_ph;
          bus.rvalid = sl_busy && !(gap_en && gap_ph);
        end
        bus.rdata = DW'(sl_addr >> 2) + DW'(sl_beat);
        bus.rresp = (sl_busy && sl_beat == err_beat) ? 2'b10 : 2'b00;
        bus.rlast = sl_busy && (sl_beat == LW - 1);
      end
    end
  end

  initial begin
    m_owner = -1; m_beat = 0; m_prio = 0; m_ar = 1'b0; m_err = 1'b0; m_addr = '0;
    forever begin
      @(negedge clk);
      nm_rst     = rst;
      nm_req_hs  = bus.req_valid & bus.req_ready;
      nm_arv     = bus.arvalid;
      nm_ar_hs   = bus.arvalid && bus.arready;
      nm_araddr  = bus.araddr;
      nm_r_hs    = bus.rvalid && bus.rready;
      nm_last_hs = bus.rsp_valid & bus.rsp_ready & {2{bus.rsp_last}};
      mg = (bus.req_valid == 2'b11) ? m_prio : (bus.req_valid[1] ? 1 : 0);
      if (!rst) begin
        exp_rr = 2'b00; exp_arv = 1'b0; exp_rready = 1'b0; exp_rspv = 2'b00; exp_last = 1'b0;
        if (m_owner < 0) begin
          if (bus.req_valid != 2'b00) exp_rr = 2'(1 << mg);
        end else if (m_ar) begin
          exp_arv = 1'b1;
        end else begin
          exp_rready = bus.rsp_ready[m_owner];
          exp_rspv   = bus.rvalid ? 2'(1 << m_owner) : 2'b00;
          exp_last   = (m_beat == LW - 1);
        end
        chk("req_ready", bus.req_ready, exp_rr);
        chk("arvalid", bus.arvalid, exp_arv);
        chk("rready", bus.rready, exp_rready);
        chk("rsp_valid", bus.rsp_valid, exp_rspv);
        chk("rsp_last", bus.rsp_last, exp_last);
        chk("err", err, m_err);
        if (exp_arv) begin
          chk("araddr", bus.araddr, m_addr);
          chk("arlen", bus.arlen, 64'(LW - 1));
          chk("arsize", bus.arsize, 64'h2);
          chk("arburst", bus.arburst, 64'h1);
        end
        if (exp_rspv != 2'b00) chk("rsp_data", bus.rsp_data, 64'((m_addr >> 2) + AW'(m_beat)));

        if (nm_req_hs != 2'b00) begin
          hs_order.push_back(nm_req_hs[1] ? 1 : 0);
          hs_cyc.push_back(cyc);
        end
        if (bus.arvalid && !bus.arready) ar_stall++;
        if (nm_ar_hs) begin
          ar_cap_addr = bus.araddr;
          ar_cap_len  = bus.arlen;
        end
        for (int i = 0; i < 2; i++) begin
          if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
            if (i == 0) log0.push_back(bus.rsp_data);
            else        log1.push_back(bus.rsp_data);
            err_log.push_back(err);
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (bus.rsp_last) begin
              n_lastflag++;
              lastflag_pos = (i == 0) ? log0.size() - 1 : log1.size() - 1;
            end
          end
        end
      end
      if (rst) begin
        m_owner = -1; m_ar = 1'b0; m_beat = 0; m_prio = 0; m_err = 1'b0;
      end else if (m_owner < 0) begin
        if (bus.req_valid != 2'b00) begin
          m_owner = mg; m_ar = 1'b1; m_beat = 0;
          m_addr = bus.req_addr[mg] & LMASK;
        end
      end else if (m_ar) begin
        if (bus.arready) m_ar = 1'b0;
      end else if (bus.rvalid && bus.rsp_ready[m_owner]) begin
`ifdef REFILL_ARB_ERR_CHECK_EN
        if (bus.rresp != 2'b00 || bus.rlast != (m_beat == LW - 1)) m_err = 1'b1;
`endif
        m_beat++;
        if (m_beat == LW) begin
          m_prio  = 1 - m_owner;
          m_owner = -1;
        end
      end
    end
  end

  task automatic clear_logs();
    hs_order.delete(); hs_cyc.delete(); log0.delete(); log1.delete(); err_log.delete();
    first_beat_cyc = -1; last_beat_cyc = -1; n_lastflag = 0; lastflag_pos = -1; ar_stall = 0;
  endtask

  task automatic start(input int p0, input logic [AW-1:0] b0, input int p1, input logic [AW-1:0] b1);
    @(negedge clk);
    #1;
    clear_logs();
    pend[0] = p0; base[0] = b0; done_cnt[0] = 0;
    pend[1] = p1; base[1] = b1; done_cnt[1] = 0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(pend[0] == 0 && pend[1] == 0 && !waiting[0] && !waiting[1] && !sl_busy && m_owner < 0)) begin
      @(posedge clk);
      n++;
      if (n > limit) begin
        n_cmp++; n_bad++;
        $display("FAIL wait_idle: timeout after %0d cycles", n);
        break;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst = 1'b1;
    repeat (2) @(posedge clk);
    #2; rst = 1'b0;
  endtask

  initial begin
    int n;
    pend = '{0, 0}; done_cnt = '{0, 0}; base = '{32'h0, 32'h0};
    stall_en = 1'b0; gap_en = 1'b0; ar_delay = 0; err_beat = -1;
    clear_logs();
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_req_ready", bus.req_ready, 64'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 64'h0);
    chk("rst_rsp_last", bus.rsp_last, 64'h0);
    chk("rst_rsp_data", bus.rsp_data, 64'h0);
    chk("rst_arvalid", bus.arvalid, 64'h0);
    chk("rst_ar_fields", {bus.araddr, bus.arlen, bus.arsize, bus.arburst}, 64'h0);
    chk("rst_rready", bus.rready, 64'h0);
    chk("rst_err", err, 64'h0);

    // Instruction-only fill
    start(1, 32'h0000_0204, 0, 32'h0);
    wait_idle(100);
    chk("t1_grants", hs_order.size(), 1);
    chk("t1_grant0", hs_order[0], 0);
    chk("t1_araddr", ar_cap_addr, 64'h200);
    chk("t1_arlen", ar_cap_len, 64'h3);
    chk("t1_beats0", log0.size(), 4);
    for (int k = 0; k < 4; k++) chk("t1_data", log0[k], 64'(32'h80 + k));
    chk("t1_beats1", log1.size(), 0);
    chk("t1_lastflags", n_lastflag, 1);
    chk("t1_lastpos", lastflag_pos, 3);
    chk("t1_first_lat", first_beat_cyc - hs_cyc[0], 2);
    chk("t1_last_lat", last_beat_cyc - hs_cyc[0], 5);

    // Simultaneous requests straight after reset
    do_reset();
    start(1, 32'h0000_0200, 1, 32'h0000_1000);
    wait_idle(100);
    chk("t2_grants", hs_order.size(), 2);
    chk("t2_first", hs_order[0], 0);
    chk("t2_second", hs_order[1], 1);
    chk("t2_gap", hs_cyc[1] - hs_cyc[0], 6);
    chk("t2_d0", log1[0], 64'h400);
    chk("t2_d3", log1[3], 64'h403);

    // Continuous contention: four fills
    start(2, 32'h0000_2000, 2, 32'h0000_3000);
    wait_idle(200);
    chk("t3_grants", hs_order.size(), 4);
    for (int k = 0; k < 4; k++) chk("t3_order", hs_order[k], k % 2);
    chk("t3_i_fill2", log0[4], 64'h804);
    chk("t3_d_fill1", log1[0], 64'hC00);

    // Slow AR, gapped R, requester stalls
    ar_delay = 5; gap_en = 1'b1; stall_en = 1'b1;
    start(1, 32'h0000_041C, 0, 32'h0);
    wait_idle(300);
    chk("t4_ar_stall", ar_stall, 5);
    chk("t4_araddr", ar_cap_addr, 64'h410);
    chk("t4_beats", log0.size(), 4);
    for (int k = 0; k < 4; k++) chk("t4_data", log0[k], 64'(32'h104 + k));
    ar_delay = 0; gap_en = 1'b0; stall_en = 1'b0;

    // Reset on the second beat
    start(1, 32'h0000_0300, 0, 32'h0);
    n = 0;
    while (!(log0.size() == 1 && bus.rsp_valid[0]) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("t5_reached_beat2", log0.size(), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t5_rsp_valid", bus.rsp_valid, 64'h0);
    chk("t5_arvalid", bus.arvalid, 64'h0);
    chk("t5_rready", bus.rready, 64'h0);
    chk("t5_rsp_last", bus.rsp_last, 64'h0);
    chk("t5_rsp_data", bus.rsp_data, 64'h0);
    chk("t5_ar_fields", {bus.araddr, bus.arlen, bus.arsize, bus.arburst}, 64'h0);
    @(posedge clk); #2; rst = 1'b0;
    start(0, 32'h0, 1, 32'h0000_1000);
    @(negedge clk); #1;
    chk("t5_data_grant", bus.req_ready, 64'h2);
    wait_idle(100);
    chk("t5_d_beats", log1.size(), 4);
    chk("t5_d_last", log1[3], 64'h403);

`ifdef REFILL_ARB_ERR_CHECK_EN
    // SLVERR on the third beat
    err_beat = 2;
    start(1, 32'h0000_0500, 0, 32'h0);
    wait_idle(100);
    err_beat = -1;
    chk("t6_beats", log0.size(), 4);
    chk("t6_err_b3", err_log[2], 0);
    chk("t6_err_b4", err_log[3], 1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("t6_err_sticky", err, 64'h1);
    do_reset();
    @(negedge clk); #1;
    chk("t6_err_cleared", err, 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
